// File: rtl/pci_pkg.sv
// Shared PCI constants and the initiator state encoding.
// The slave-side command decoder imports the same command codes.
package pci_pkg;

  localparam logic [3:0] PCI_CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] PCI_CMD_MEM_WRITE = 4'b0111;
  localparam logic [3:0] PCI_BE_ALL        = 4'b0000;
  localparam logic [3:0] PCI_BE_IDLE       = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_ABORT = 3'd3,
    ST_TURN  = 3'd4
  } init_state_t;

  function automatic logic [3:0] mem_cmd(input logic write);
    return write ? PCI_CMD_MEM_WRITE : PCI_CMD_MEM_READ;
  endfunction

endpackage

// File: rtl/pci_devsel_timer.sv
// DEVSEL# watchdog: loaded when the address phase ends, counts down while DEVSEL# is high.
// Sampling DEVSEL# low latches hit and freezes the count for the rest of the transaction.
module pci_devsel_timer #(
  parameter int TIMEOUT = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic devsel_n,
  output logic hit,
  output logic expired
);

  logic [3:0] cnt;
  logic       running;

  assign running = (cnt != 4'd0) && !hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
      hit <= 1'b0;
    end else if (start) begin
      cnt <= 4'(TIMEOUT);
      hit <= 1'b0;
    end else if (running) begin
      if (!devsel_n) hit <= 1'b1;
      else           cnt <= cnt - 4'd1;
    end
  end

  // True on the edge that would take the count to zero: the TIMEOUT-th unclaimed edge.
  assign expired = running && devsel_n && (cnt == 4'd1);

endmodule

// File: rtl/pci_master_initiator.sv
// PCI memory read/write initiator: address phase, burst data phases, master abort.
// All bus-facing outputs are registered; the next values come from the output decoder.
module pci_master_initiator
  import pci_pkg::*;
#(
  parameter int DEVSEL_TIMEOUT = 5,
  parameter int LEN_W          = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [31:0]      wr_data,
  output logic             wr_pop,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             err,
  output logic             frame_n,
  output logic             irdy_n,
  output logic [3:0]       cbe_n,
  output logic [31:0]      ad_out,
  output logic             ad_oe,
  input  logic [31:0]      ad_in,
  input  logic             trdy_n,
  input  logic             devsel_n
);

  localparam logic [LEN_W-1:0] REM_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] REM_TWO = LEN_W'(2);

  init_state_t      state, state_nxt;
  logic             wr_q;
  logic [LEN_W-1:0] rem;
  logic             accept;
  logic             phase_done;
  logic             last_phase;
  logic             devsel_hit;
  logic             timer_expired;

  logic             frame_n_d, irdy_n_d, ad_oe_d;
  logic [3:0]       cbe_n_d;
  logic [31:0]      ad_out_d, rd_data_d;
  logic             wr_pop_d, rd_valid_d, done_d, err_d;

  assign req_ready  = (state == ST_IDLE);
  assign accept     = req_valid && req_ready;
  assign phase_done = (state == ST_DATA) && !irdy_n && !trdy_n && !devsel_n;
  assign last_phase = (rem == REM_ONE);

  pci_devsel_timer #(
    .TIMEOUT (DEVSEL_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (state == ST_ADDR),
    .devsel_n (devsel_n),
    .hit      (devsel_hit),
    .expired  (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ADDR;
      ST_ADDR:  state_nxt = ST_DATA;
      ST_DATA: begin
        if (phase_done && last_phase)         state_nxt = ST_TURN;
        else if (timer_expired && !devsel_hit) state_nxt = ST_ABORT;
      end
      ST_ABORT: state_nxt = ST_TURN;
      ST_TURN:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Transaction context; rem is held at 1 on the final phase so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= 1'b0;
      rem  <= REM_ONE;
    end else if (accept) begin
      wr_q <= req_write;
      rem  <= (req_len == '0) ? REM_ONE : req_len;
    end else if (phase_done && !last_phase) begin
      rem <= rem - REM_ONE;
    end
  end

  always_comb begin
    frame_n_d  = frame_n;
    irdy_n_d   = irdy_n;
    cbe_n_d    = cbe_n;
    ad_out_d   = ad_out;
    ad_oe_d    = ad_oe;
    rd_data_d  = rd_data;
    wr_pop_d   = 1'b0;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          frame_n_d = 1'b0;
          irdy_n_d  = 1'b1;
          cbe_n_d   = mem_cmd(req_write);
          ad_out_d  = req_addr;
          ad_oe_d   = 1'b1;
        end
      end
      ST_ADDR: begin
        frame_n_d = last_phase;
        irdy_n_d  = 1'b0;
        cbe_n_d   = PCI_BE_ALL;
        ad_oe_d   = wr_q;
        if (wr_q) ad_out_d = wr_data;
      end
      ST_DATA: begin
        // Write data follows wr_data so a word advanced after wr_pop reaches the bus.
        if (wr_q) ad_out_d = wr_data;
        if (phase_done) begin
          wr_pop_d   = wr_q;
          rd_valid_d = !wr_q;
          if (!wr_q) rd_data_d = ad_in;
          if (last_phase) begin
            frame_n_d = 1'b1;
            irdy_n_d  = 1'b1;
            cbe_n_d   = PCI_BE_IDLE;
            ad_oe_d   = 1'b0;
            done_d    = 1'b1;
          end else begin
            frame_n_d = (rem == REM_TWO);
          end
        end else if (timer_expired && !devsel_hit) begin
          frame_n_d = 1'b1;
          irdy_n_d  = 1'b0;
        end
      end
      ST_ABORT: begin
        frame_n_d = 1'b1;
        irdy_n_d  = 1'b1;
        cbe_n_d   = PCI_BE_IDLE;
        ad_oe_d   = 1'b0;
        done_d    = 1'b1;
        err_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_n  <= 1'b1;
      irdy_n   <= 1'b1;
      cbe_n    <= PCI_BE_IDLE;
      ad_out   <= 32'h0;
      ad_oe    <= 1'b0;
      rd_data  <= 32'h0;
      wr_pop   <= 1'b0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      frame_n  <= frame_n_d;
      irdy_n   <= irdy_n_d;
      cbe_n    <= cbe_n_d;
      ad_out   <= ad_out_d;
      ad_oe    <= ad_oe_d;
      rd_data  <= rd_data_d;
      wr_pop   <= wr_pop_d;
      rd_valid <= rd_valid_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

endmodule
